// File: rtl/inst_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction memory loader.
package inst_loader_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ADDR_W         = 10;
  localparam int unsigned LEN_W          = ADDR_W - 1;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned DEPTH_W        = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when a requested word count does not fit in instruction memory.
  function automatic logic len_overflow(input logic [LEN_W-1:0] len);
    return 32'(len) > 32'(DEPTH_W);
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Host byte stream, control and instruction-memory write port of the loader.
interface inst_mem_loader_if;
  import inst_loader_pkg::*;

  logic              start;
  logic [LEN_W-1:0]  len;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output start, len, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );

  modport slave (
    input  start, len, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );

endinterface

// File: rtl/inst_mem_loader_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; pulses word_valid
// for one cycle after the fourth byte of each word.
module byte_packer
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic [1:0]        byte_cnt
);

  localparam int unsigned SR_W = DATA_W - 8;

  logic [SR_W-1:0] sr_q;

  // Byte counter, shift register and completed-word register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q       <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      sr_q       <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_en) begin
        sr_q     <= {sr_q[SR_W-9:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
          word       <= {sr_q, byte_in};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Streams a program into instruction memory word by word while holding
// the datapath stalled until the last word has been written.
module inst_mem_loader
  import inst_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  inst_mem_loader_if.slave   bus
);

  state_t           state_q, state_n;
  logic             byte_ready_q, byte_ready_n;
  logic             cpu_hold_q, cpu_hold_n;
  logic             done_q, done_n;
  logic             err_q, err_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] word_idx_q;

  logic             start_ok_c;
  logic             accept_c;
  logic             last_byte_c;

  logic [1:0]        byte_cnt;
  logic [DATA_W-1:0] word;
  logic              word_valid;

  assign accept_c    = bus.byte_valid & byte_ready_q;
  // Final byte of the final word: word_idx already counts earlier writes.
  assign last_byte_c = accept_c
                    && (byte_cnt == 2'(BYTES_PER_WORD - 1))
                    && (word_idx_q == len_q - LEN_W'(1));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok_c),
    .byte_en    (accept_c),
    .byte_in    (bus.byte_in),
    .word       (word),
    .word_valid (word_valid),
    .byte_cnt   (byte_cnt)
  );

  // State and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_ready_q <= 1'b0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      len_q        <= '0;
    end else begin
      state_q      <= state_n;
      byte_ready_q <= byte_ready_n;
      cpu_hold_q   <= cpu_hold_n;
      done_q       <= done_n;
      err_q        <= err_n;
      len_q        <= len_n;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n      = state_q;
    byte_ready_n = byte_ready_q;
    cpu_hold_n   = cpu_hold_q;
    done_n       = done_q;
    err_n        = err_q;
    len_n        = len_q;
    start_ok_c   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        byte_ready_n = 1'b0;
        cpu_hold_n   = 1'b0;
        if (bus.start) begin
          start_ok_c = 1'b1;
          if (bus.len == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
            err_n   = 1'b0;
          end else if (len_overflow(bus.len)) begin
            state_n = DONE;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n      = LOAD;
            len_n        = bus.len;
            done_n       = 1'b0;
            err_n        = 1'b0;
            cpu_hold_n   = 1'b1;
            byte_ready_n = 1'b1;
          end
        end
      end
      LOAD: begin
        if (last_byte_c) begin
          state_n      = DONE;
          byte_ready_n = 1'b0;
          done_n       = 1'b1;
        end
      end
      default: begin
        state_n      = IDLE;
        byte_ready_n = 1'b0;
        cpu_hold_n   = 1'b0;
      end
    endcase
  end

  // Word index advances after each write; a new load restarts it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx_q <= '0;
    end else if (start_ok_c) begin
      word_idx_q <= '0;
    end else if (word_valid) begin
      word_idx_q <= word_idx_q + LEN_W'(1);
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = word_valid;
  assign bus.mem_addr   = ADDR_W'({word_idx_q, 2'b00});
  assign bus.mem_wdata  = word;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule
